// File: rtl/acia_uart_core.sv
// rtl/acia_uart_core.sv - ACIA1 8N1 UART: data/status/baud registers, 16x-oversampled RX, level IRQ.
module acia_uart_core #(
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd27,
  parameter int          SYNC_STAGES     = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Address,
  input  logic        AS_L,
  input  logic        WE_L,
  input  logic        ACIA1_Port_Enable,
  input  logic        ACIA1_Baud_Enable,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        IRQ,
  output logic        TxD,
  input  logic        RxD
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic                   acc_prev_q;
  logic [15:0]            div_q, div_d, tcnt_q, tcnt_d;
  logic [1:0]             ctrl_q, ctrl_d;
  logic                   irq_q, irq_d;
  state_e                 tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [3:0]             tx_tcnt_q, tx_tcnt_d, rx_tcnt_q, rx_tcnt_d;
  logic [2:0]             tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]             tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d;
  logic [7:0]             rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic                   tx_empty_q, tx_empty_d, rx_full_q, rx_full_d;
  logic                   ovr_q, ovr_d, frm_q, frm_d;
  logic [SYNC_STAGES-1:0] sync_q;

  logic port_sel, baud_sel, acc_now, first, wr_data, wr_ctrl, wr_div, pop;
  logic tick, rx_s, rx_done, tx_busy;
  logic [15:0] div_eff;
  logic unused_ok;

  assign port_sel = ACIA1_Port_Enable & ~AS_L;
  assign baud_sel = ACIA1_Baud_Enable & ~AS_L;
  assign acc_now  = port_sel | baud_sel;
  // Side effects fire only on the first cycle of an access, however long the strobe is held.
  assign first    = acc_now & ~acc_prev_q;
  assign wr_data  = first & ~WE_L & port_sel & (Address == 4'h0);
  assign wr_ctrl  = first & ~WE_L & port_sel & (Address == 4'h4);
  assign wr_div   = first & ~WE_L & baud_sel & (Address == 4'h8);
  assign pop      = first &  WE_L & port_sel & (Address == 4'h0);

  assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;
  assign tick     = (tcnt_q == div_eff - 16'd1);
  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign tx_busy  = (tx_state_q != S_IDLE);
  assign IRQ      = irq_q;
  assign TxD      = (tx_state_q == S_START) ? 1'b0 :
                    (tx_state_q == S_DATA)  ? tx_shift_q[0] : 1'b1;
  assign unused_ok = ^{DataIn[31:16], DataIn[6:2]};

  always_comb begin
    DataOut = '0;
    if (port_sel && Address == 4'h0)
      DataOut = {24'b0, rx_data_q};
    else if (port_sel && Address == 4'h4)
      DataOut = {24'b0, irq_q, 2'b0, ovr_q, frm_q, tx_busy, tx_empty_q, rx_full_q};
    else if (baud_sel && Address == 4'h8)
      DataOut = {16'b0, div_q};
  end

  always_comb begin
    div_d      = div_q;
    tcnt_d     = tick ? 16'd0 : tcnt_q + 16'd1;
    ctrl_d     = ctrl_q;
    irq_d      = (ctrl_q[0] & rx_full_q) | (ctrl_q[1] & tx_empty_q);
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_full_d  = rx_full_q;
    ovr_d      = ovr_q;
    frm_d      = frm_q;
    rx_done    = 1'b0;

    if (wr_div) begin
      div_d  = DataIn[15:0];
      tcnt_d = 16'd0;
    end
    if (wr_data && tx_empty_q) begin
      tx_hold_d  = DataIn[7:0];
      tx_empty_d = 1'b0;
    end

    if (tick) begin
      case (tx_state_q)
        S_IDLE: if (!tx_empty_q) begin
          tx_shift_d = tx_hold_q;
          tx_empty_d = 1'b1;
          tx_tcnt_d  = 4'd0;
          tx_state_d = S_START;
        end
        S_START: begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            tx_bit_d   = 3'd0;
            tx_state_d = S_DATA;
          end
        end
        S_DATA: begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          end
        end
        default: begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            // A queued byte starts straight away, no idle bit between frames.
            if (!tx_empty_q) begin
              tx_shift_d = tx_hold_q;
              tx_empty_d = 1'b1;
              tx_state_d = S_START;
            end else begin
              tx_state_d = S_IDLE;
            end
          end
        end
      endcase
    end

    case (rx_state_q)
      S_IDLE: if (!rx_s) begin
        rx_tcnt_d  = 4'd0;
        rx_state_d = S_START;
      end
      S_START: if (tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == 4'd7) begin
          rx_tcnt_d  = 4'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: if (tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == 4'd15) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end
      end
      default: if (tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == 4'd15) begin
          rx_done    = 1'b1;
          rx_state_d = S_IDLE;
        end
      end
    endcase

    if (wr_ctrl) begin
      ctrl_d = DataIn[1:0];
      if (DataIn[7]) begin
        ovr_d = 1'b0;
        frm_d = 1'b0;
      end
    end
    if (pop) rx_full_d = 1'b0;
    // A completion coinciding with the pop sees an empty buffer.
    if (rx_done) begin
      if (!rx_full_q || pop) begin
        rx_data_d = rx_shift_q;
        rx_full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
      if (!rx_s) frm_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc_prev_q <= 1'b0;
      div_q      <= DEFAULT_DIVISOR;
      tcnt_q     <= 16'd0;
      ctrl_q     <= 2'b0;
      irq_q      <= 1'b0;
      tx_state_q <= S_IDLE;
      tx_tcnt_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_hold_q  <= 8'd0;
      tx_empty_q <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_tcnt_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_full_q  <= 1'b0;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
      sync_q     <= '1;
    end else begin
      acc_prev_q <= acc_now;
      div_q      <= div_d;
      tcnt_q     <= tcnt_d;
      ctrl_q     <= ctrl_d;
      irq_q      <= irq_d;
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tx_empty_q <= tx_empty_d;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_full_q  <= rx_full_d;
      ovr_q      <= ovr_d;
      frm_q      <= frm_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], RxD};
    end
  end

endmodule

// File: doc/acia_uart_core.md
Name: acia_uart_core

Overview:
- Serial port peripheral behind the ACIA1 I/O decode, and the consumer of its two enables.
- ACIA1_Port_Enable selects the data register (offset 0x0) and the control/status register (offset 0x4).
- ACIA1_Baud_Enable selects the baud divisor register (offset 0x8).
- Implements an 8N1 UART with a one-byte TX holding register, a one-byte RX buffer, a 16x-oversampling receiver and a level interrupt to the CPU.

Parameters:
- DEFAULT_DIVISOR, 16'd27: reset value of the baud divisor. Oversample tick period in clocks = divisor, with 0 treated as 1.
- SYNC_STAGES, 2: number of flops in the RxD metastability synchroniser.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Address  input  4  byte offset within the ACIA1 window (Address[3:0] of the CPU bus).
- AS_L  input  1  address strobe, active low.
- WE_L  input  1  write enable, active low; a high level means the access is a read.
- ACIA1_Port_Enable  input  1  decoded select for offsets 0x0 and 0x4.
- ACIA1_Baud_Enable  input  1  decoded select for offset 0x8.
- DataIn  input  32  CPU write data.
- DataOut  output  32  read data; zero when the block is not selected.
- IRQ  output  1  level interrupt request, active high.
- TxD  output  1  serial output; idles high.
- RxD  input  1  serial input; asynchronous to Clock.

Behaviour:
- Reset values:
  - TxD=1, IRQ=0, DataOut=0.
  - divisor=DEFAULT_DIVISOR, control=0.
  - TX holding empty, TX shifter idle, RX_Full=0, Overrun=0, Framing=0.
  - Tick counter cleared; both FSMs in IDLE.
- Access qualification:
  - A bus access is any cycle with a select high and AS_L=0.
  - Side effects (write, RX pop) act once, on the first cycle of an access: select high in this cycle and low in the previous one (registered).
  - Holding the strobe for several cycles therefore produces one side effect.
- Reads are combinational from registers:
  - 0x0: {24'b0, rx_data}. The first cycle of the access clears RX_Full.
  - 0x4: {24'b0, IRQ, 2'b0, Overrun, Framing, TX_Busy, TX_Empty, RX_Full}. Has no side effects.
  - 0x8: {16'b0, divisor}.
  - Any other offset reads 0.
- Writes:
  - 0x0: DataIn[7:0] loads the TX holding register if TX_Empty=1. If the holding register is occupied, the write is silently dropped.
  - 0x4: bit0 = RX interrupt enable, bit1 = TX interrupt enable. Writing bit7=1 clears Overrun and Framing; bit7 is not stored.
  - 0x8: DataIn[15:0] loads the divisor and clears the tick counter in the same edge.
- Tick generator: a 16-bit counter pulses tick for one clock every max(divisor,1) clocks.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Each state lasts 16 ticks. DATA shifts 8 bits, LSB first.
  - In IDLE, a non-empty holding register moves to the shifter on the next tick. TX_Empty sets that same cycle, so a back-to-back byte may be queued immediately.
  - STOP drives TxD=1 and returns to IDLE. If the holding register is already full, the next START begins with no extra idle bit.
  - TX_Busy = FSM not in IDLE.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE, running on the synchronised RxD.
  - IDLE: a synchronised level of 0 moves to START and resets the tick phase count.
  - START: samples at tick 8. If RxD=1 there, the start was a glitch and the FSM returns to IDLE.
  - DATA: samples every 16 ticks, 8 bits, LSB first.
  - STOP: samples at 16 ticks.
    - Stop=0 sets Framing; the byte is still delivered.
    - If RX_Full=0 on completion, load rx_data and set RX_Full.
    - If RX_Full=1, discard the new byte, keep the old byte and set Overrun.
- Simultaneous events: an RX completion in the same cycle as the pop of 0x0 counts as an empty buffer. The new byte is loaded, RX_Full stays 1, and there is no overrun.
- IRQ (registered) = (ctrl0 & RX_Full) | (ctrl1 & TX_Empty). It updates one cycle after its cause.
- Writing the divisor mid-frame does not abort either FSM; the new rate applies from the next tick.
- Reset asserted mid-frame returns everything to reset values at the next edge; TxD goes high.

Test Plan:
- Reset, then read 0x4, 0x8 and 0x0 -> 0x00000002 (TX_Empty only), 0x0000001B, 0x00000000; TxD=1, IRQ=0.
- Write 0x8=1, write 0x0=0xA5 -> TxD low for 16 clocks, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, then high. Status reads 0x6 while busy and 0x2 after.
- Write 0x0=0x11, then 0x22, then 0x33 before the first START ends -> 0x11 and 0x22 are transmitted back-to-back and 0x33 is dropped.
- Divisor=1; drive RxD with frame 0x3C -> RX_Full=1. With ctrl=0x01, IRQ=1. A read of 0x0 held 5 cycles returns 0x3C and clears RX_Full once; IRQ falls the following cycle.
- Send two frames without reading -> Overrun=1 and rx_data still holds the first byte. Write 0x4=0x80 -> Overrun=0.
- Send a 0x55 frame with stop=0 -> Framing=1, byte 0x55 delivered. Separately, a 4-clock low glitch on RxD -> no byte and the FSM back in IDLE.
